// File: rtl/fifo_circular_param.sv
// Parametrised circular-buffer FIFO with standard or first-word-fall-through read,
// programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module fifo_circular_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 32,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic                         CLOCK,
    input  logic                         RESET,
    input  logic                         CLEAR_N,
    input  logic [WIDTH-1:0]             DATA_IN,
    input  logic                         WRITE,
    input  logic                         READ,
    output logic [WIDTH-1:0]             DATA_OUT,
    output logic [$clog2(DEPTH+1)-1:0]   USE_DW,
    output logic                         F_FULL_N,
    output logic                         F_EMPTY_N,
    output logic                         F_LAST_N,
    output logic                         F_FIRST_N,
    output logic                         F_ALMOST_FULL_N,
    output logic                         F_ALMOST_EMPTY_N,
    output logic                         OVERFLOW,
    output logic                         UNDERFLOW
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             empty_s, full_s;
    logic             bypass_s, rd_acc_s, wr_acc_s, mem_we_s;

    // Pointers wrap by explicit compare so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    assign empty_s  = (count_q == {CW{1'b0}});
    assign full_s   = (count_q == CW'(DEPTH));
    // Standard mode forwards a write straight to the output when empty.
    assign bypass_s = (FWFT == 0) && empty_s && READ && WRITE;
    assign rd_acc_s = READ && !empty_s;
    assign wr_acc_s = WRITE && (!full_s || rd_acc_s) && !bypass_s;
    assign mem_we_s = wr_acc_s && CLEAR_N;

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (!CLEAR_N) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_acc_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (WRITE && full_s && !rd_acc_s) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
            if (READ && empty_s && !bypass_s) begin
                unf_d = 1'b1;
            end else begin
                unf_d = unf_q;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge CLOCK) begin
        if (mem_we_s) begin
            mem_q[wr_ptr_q] <= DATA_IN;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign DATA_OUT = empty_s ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];
        end else begin : g_std
            logic [WIDTH-1:0] dout_q, dout_d;

            // Output word: cleared, bypassed, popped or held.
            always_comb begin
                dout_d = dout_q;
                if (!CLEAR_N) begin
                    dout_d = {WIDTH{1'b0}};
                end else if (bypass_s) begin
                    dout_d = DATA_IN;
                end else if (rd_acc_s) begin
                    dout_d = mem_q[rd_ptr_q];
                end else begin
                    dout_d = dout_q;
                end
            end

            // Registered read data.
            always_ff @(posedge CLOCK or posedge RESET) begin
                if (RESET) begin
                    dout_q <= {WIDTH{1'b0}};
                end else begin
                    dout_q <= dout_d;
                end
            end

            assign DATA_OUT = dout_q;
        end
    endgenerate

    assign USE_DW           = count_q;
    assign F_FULL_N         = !full_s;
    assign F_EMPTY_N        = !empty_s;
    assign F_LAST_N         = !(count_q == CW'(DEPTH - 1));
    assign F_FIRST_N        = !(count_q == CW'(1));
    assign F_ALMOST_FULL_N  = !(int'(count_q) >= AF_LEVEL);
    assign F_ALMOST_EMPTY_N = !(int'(count_q) <= AE_LEVEL);
    assign OVERFLOW         = ovf_q;
    assign UNDERFLOW        = unf_q;

endmodule

// File: tb/tb_fifo_circular_param.sv
// Directed bench for fifo_circular_param: a standard-mode and an FWFT instance,
// both DEPTH=4, AF_LEVEL=3, AE_LEVEL=1.
module tb_fifo_circular_param;

    logic       clk;
    logic       rst;
    // standard-mode instance
    logic       clr_n, wr, rd;
    logic [7:0] din;
    logic [7:0] dout;
    logic [2:0] cnt;
    logic       full_n, empty_n, last_n, first_n, af_n, ae_n, ovf, unf;
    logic [7:0] flags;
    // FWFT instance
    logic       f_clr_n, f_wr, f_rd;
    logic [7:0] f_din;
    logic [7:0] f_dout;
    logic [2:0] f_cnt;
    logic       f_full_n, f_empty_n, f_last_n, f_first_n, f_af_n, f_ae_n, f_ovf, f_unf;

    int total = 0;
    int bad   = 0;

    assign flags = {full_n, empty_n, last_n, first_n, af_n, ae_n, ovf, unf};

    fifo_circular_param #(.WIDTH(8), .DEPTH(4), .FWFT(0), .AF_LEVEL(3), .AE_LEVEL(1)) dut_std (
        .CLOCK(clk), .RESET(rst), .CLEAR_N(clr_n), .DATA_IN(din), .WRITE(wr), .READ(rd),
        .DATA_OUT(dout), .USE_DW(cnt), .F_FULL_N(full_n), .F_EMPTY_N(empty_n),
        .F_LAST_N(last_n), .F_FIRST_N(first_n), .F_ALMOST_FULL_N(af_n),
        .F_ALMOST_EMPTY_N(ae_n), .OVERFLOW(ovf), .UNDERFLOW(unf)
    );

    fifo_circular_param #(.WIDTH(8), .DEPTH(4), .FWFT(1), .AF_LEVEL(3), .AE_LEVEL(1)) dut_fwft (
        .CLOCK(clk), .RESET(rst), .CLEAR_N(f_clr_n), .DATA_IN(f_din), .WRITE(f_wr), .READ(f_rd),
        .DATA_OUT(f_dout), .USE_DW(f_cnt), .F_FULL_N(f_full_n), .F_EMPTY_N(f_empty_n),
        .F_LAST_N(f_last_n), .F_FIRST_N(f_first_n), .F_ALMOST_FULL_N(f_af_n),
        .F_ALMOST_EMPTY_N(f_ae_n), .OVERFLOW(f_ovf), .UNDERFLOW(f_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr_n = 1'b1; wr = 1'b0; rd = 1'b0; din = 8'h00;
        f_clr_n = 1'b1; f_wr = 1'b0; f_rd = 1'b0; f_din = 8'h00;
        repeat (2) step();
        total++; if (cnt !== 3'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
        total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", dout); end
        total++; if (flags !== 8'b1011_1000) begin bad++; $display("FAIL reset_flags got=%b exp=10111000", flags); end
        rst = 1'b0;
        step();
        total++; if (flags !== 8'b1011_1000) begin bad++; $display("FAIL idle_flags got=%b exp=10111000", flags); end
        total++; if (f_dout !== 8'h00 || f_empty_n !== 1'b0) begin bad++; $display("FAIL fwft_reset got=%h/%b exp=00/0", f_dout, f_empty_n); end
    endtask

    task automatic test_fill_drain();
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = vals[i];
            step();
            total++; if (cnt !== 3'(i + 1)) begin bad++; $display("FAIL fill_cnt got=%0d exp=%0d", cnt, i + 1); end
        end
        wr = 1'b0;
        total++; if (flags !== 8'b0111_0100) begin bad++; $display("FAIL full_flags got=%b exp=01110100", flags); end
        rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (dout !== vals[i]) begin bad++; $display("FAIL drain_data got=%h exp=%h", dout, vals[i]); end
            total++; if (cnt !== 3'(3 - i)) begin bad++; $display("FAIL drain_cnt got=%0d exp=%0d", cnt, 3 - i); end
        end
        rd = 1'b0;
        total++; if (empty_n !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", empty_n); end
    endtask

    task automatic test_wrap();
        logic [7:0] d;
        d = 8'h80;
        for (int b = 0; b < 10; b++) begin
            wr = 1'b1;
            din = d;               step();
            din = d + 8'd1;        step();
            total++; if (cnt !== 3'd2) begin bad++; $display("FAIL wrap_cnt got=%0d exp=2", cnt); end
            wr = 1'b0; rd = 1'b1;
            step();
            total++; if (dout !== d) begin bad++; $display("FAIL wrap_data0 got=%h exp=%h", dout, d); end
            step();
            total++; if (dout !== d + 8'd1) begin bad++; $display("FAIL wrap_data1 got=%h exp=%h", dout, d + 8'd1); end
            rd = 1'b0;
            d = d + 8'd2;
        end
        total++; if ({ovf, unf, cnt} !== 5'b00_000) begin bad++; $display("FAIL wrap_err got=%b%b cnt=%0d exp=00 cnt=0", ovf, unf, cnt); end
    endtask

    task automatic test_full_empty();
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = vals[i];
            step();
        end
        din = 8'h55;
        step();
        wr = 1'b0;
        total++; if (ovf !== 1'b1 || cnt !== 3'd4) begin bad++; $display("FAIL overflow got=%b cnt=%0d exp=1 cnt=4", ovf, cnt); end
        rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (dout !== vals[i]) begin bad++; $display("FAIL ovf_drain got=%h exp=%h", dout, vals[i]); end
        end
        step();
        rd = 1'b0;
        total++; if (unf !== 1'b1 || dout !== 8'h44 || cnt !== 3'd0) begin
            bad++; $display("FAIL underflow got=%b dout=%h cnt=%0d exp=1 dout=44 cnt=0", unf, dout, cnt);
        end
    endtask

    task automatic test_thresholds_clear();
        wr = 1'b1;
        din = 8'hC1; step();
        total++; if (flags !== 8'b1110_1011) begin bad++; $display("FAIL cnt1_flags got=%b exp=11101011", flags); end
        din = 8'hC2; step();
        total++; if (flags !== 8'b1111_1111) begin bad++; $display("FAIL cnt2_flags got=%b exp=11111111", flags); end
        din = 8'hC3; step();
        wr = 1'b0;
        total++; if (flags !== 8'b1101_0111 || cnt !== 3'd3) begin bad++; $display("FAIL cnt3_flags got=%b cnt=%0d exp=11010111 cnt=3", flags, cnt); end
        clr_n = 1'b0; wr = 1'b1; rd = 1'b1; din = 8'hEE;
        step();
        clr_n = 1'b1; wr = 1'b0; rd = 1'b0;
        total++; if (cnt !== 3'd0 || flags !== 8'b1011_1000 || dout !== 8'h00) begin
            bad++; $display("FAIL clear got cnt=%0d flags=%b dout=%h exp cnt=0 flags=10111000 dout=00", cnt, flags, dout);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp_v [4];
        exp_v[0] = 8'h02; exp_v[1] = 8'h03; exp_v[2] = 8'h04; exp_v[3] = 8'h66;
        wr = 1'b1; rd = 1'b1; din = 8'hA5;
        step();
        wr = 1'b0; rd = 1'b0;
        total++; if (dout !== 8'hA5 || cnt !== 3'd0 || unf !== 1'b0) begin
            bad++; $display("FAIL bypass got dout=%h cnt=%0d unf=%b exp A5 0 0", dout, cnt, unf);
        end
        wr = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            din = 8'(i);
            step();
        end
        rd = 1'b1; din = 8'h66;
        step();
        wr = 1'b0;
        total++; if (dout !== 8'h01 || cnt !== 3'd4 || ovf !== 1'b0) begin
            bad++; $display("FAIL full_rw got dout=%h cnt=%0d ovf=%b exp 01 4 0", dout, cnt, ovf);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (dout !== exp_v[i]) begin bad++; $display("FAIL full_rw_order got=%h exp=%h", dout, exp_v[i]); end
        end
        rd = 1'b0;
    endtask

    task automatic test_fwft();
        f_wr = 1'b1; f_din = 8'h7E;
        step();
        f_wr = 1'b0;
        total++; if (f_dout !== 8'h7E || f_cnt !== 3'd1) begin bad++; $display("FAIL fwft_head got=%h cnt=%0d exp=7e cnt=1", f_dout, f_cnt); end
        f_rd = 1'b1;
        step();
        f_rd = 1'b0;
        total++; if (f_dout !== 8'h00 || f_empty_n !== 1'b0) begin bad++; $display("FAIL fwft_pop got=%h empty_n=%b exp=00 0", f_dout, f_empty_n); end
        f_wr = 1'b1; f_rd = 1'b1; f_din = 8'h5A;
        step();
        f_wr = 1'b0; f_rd = 1'b0;
        total++; if (f_unf !== 1'b1 || f_cnt !== 3'd1 || f_dout !== 8'h5A) begin
            bad++; $display("FAIL fwft_empty_rw got unf=%b cnt=%0d dout=%h exp 1 1 5a", f_unf, f_cnt, f_dout);
        end
    endtask

    task automatic test_async_reset();
        wr = 1'b1; din = 8'h31; step();
        din = 8'h32; step();
        wr = 1'b0; rd = 1'b1; step();
        rd = 1'b0;
        total++; if (cnt !== 3'd1 || dout !== 8'h31) begin bad++; $display("FAIL pre_reset got cnt=%0d dout=%h exp 1 31", cnt, dout); end
        rst = 1'b1;
        #2;
        total++; if (cnt !== 3'd0 || dout !== 8'h00 || flags !== 8'b1011_1000) begin
            bad++; $display("FAIL async_reset got cnt=%0d dout=%h flags=%b exp 0 00 10111000", cnt, dout, flags);
        end
        total++; if (f_cnt !== 3'd0 || f_unf !== 1'b0 || f_dout !== 8'h00) begin
            bad++; $display("FAIL async_reset_fwft got cnt=%0d unf=%b dout=%h exp 0 0 00", f_cnt, f_unf, f_dout);
        end
        #1;
        rst = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_empty();
        test_thresholds_clear();
        test_simultaneous();
        test_fwft();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
